// File: rtl/pf_vscroll_ctrl.sv
// Playfield vertical scroll controller: tracks the current playfield line per
// hblank, reloading from a CPU-written scroll register at frame start or mid-frame.
module pf_vscroll_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       hblank,
    input  logic       vblank,
    input  logic       vscroll_wr,
    input  logic [8:0] vscroll_din,
    input  logic       count_en,
    input  logic       dir,
    output logic [8:0] pf_line,
    output logic [2:0] fine_y,
    output logic [5:0] tile_row,
    output logic       line_tick,
    output logic       wrap,
    output logic       pending
);

    typedef enum logic [1:0] {VBL, LOAD, ACTIVE} state_t;

    state_t     state_reg, state_next;
    logic [8:0] shadow_reg, shadow_next;
    logic [8:0] line_reg, line_next;
    logic       hblank_q_reg;
    logic       pending_reg, pending_next;
    logic       tick_reg, tick_next;
    logic       wrap_reg, wrap_next;
    logic       hb_rise;
    logic [8:0] line_step;
    logic       step_wraps;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= VBL;
            shadow_reg   <= 9'd0;
            line_reg     <= 9'd0;
            hblank_q_reg <= 1'b1;
            pending_reg  <= 1'b0;
            tick_reg     <= 1'b0;
            wrap_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            shadow_reg   <= shadow_next;
            line_reg     <= line_next;
            hblank_q_reg <= hblank;
            pending_reg  <= pending_next;
            tick_reg     <= tick_next;
            wrap_reg     <= wrap_next;
        end
    end

    always_comb begin
        hb_rise      = hblank & ~hblank_q_reg;
        line_step    = dir ? (line_reg - 9'd1) : (line_reg + 9'd1);
        step_wraps   = dir ? (line_reg == 9'd0) : (line_reg == 9'h1FF);
        state_next   = state_reg;
        shadow_next  = vscroll_wr ? vscroll_din : shadow_reg;
        line_next    = line_reg;
        pending_next = pending_reg;
        tick_next    = 1'b0;
        wrap_next    = 1'b0;

        case (state_reg)
            VBL: begin
                if (!vblank)
                    state_next = LOAD;
            end
            LOAD: begin
                // A write landing in the load cycle bypasses the shadow register.
                line_next    = vscroll_wr ? vscroll_din : shadow_reg;
                pending_next = 1'b0;
                state_next   = ACTIVE;
            end
            ACTIVE: begin
                if (vblank) begin
                    state_next = VBL;
                end else if (hb_rise) begin
                    if (pending_reg) begin
                        line_next    = shadow_reg;
                        pending_next = 1'b0;
                        tick_next    = 1'b1;
                    end else if (count_en) begin
                        line_next = line_step;
                        tick_next = 1'b1;
                        wrap_next = step_wraps;
                    end
                end
                // A write coinciding with this edge defers its reload to the next rise.
                if (vscroll_wr)
                    pending_next = 1'b1;
            end
            default: state_next = VBL;
        endcase
    end

    assign pf_line   = line_reg;
    assign fine_y    = line_reg[2:0];
    assign tile_row  = line_reg[8:3];
    assign line_tick = tick_reg;
    assign wrap      = wrap_reg;
    assign pending   = pending_reg;

endmodule

// File: tb/tb_pf_vscroll_ctrl.sv
// Table-driven bench for pf_vscroll_ctrl: each record is one clock of stimulus
// plus the outputs expected just after that clock edge.
module tb_pf_vscroll_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       hblank = 1'b0;
    logic       vblank = 1'b1;
    logic       vscroll_wr = 1'b0;
    logic [8:0] vscroll_din = 9'd0;
    logic       count_en = 1'b1;
    logic       dir = 1'b0;
    logic [8:0] pf_line;
    logic [2:0] fine_y;
    logic [5:0] tile_row;
    logic       line_tick;
    logic       wrap;
    logic       pending;

    pf_vscroll_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .hblank     (hblank),
        .vblank     (vblank),
        .vscroll_wr (vscroll_wr),
        .vscroll_din(vscroll_din),
        .count_en   (count_en),
        .dir        (dir),
        .pf_line    (pf_line),
        .fine_y     (fine_y),
        .tile_row   (tile_row),
        .line_tick  (line_tick),
        .wrap       (wrap),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       hb;
        logic       vb;
        logic       wr;
        logic [8:0] din;
        logic       en;
        logic       dn;
        logic [8:0] exp_line;
        logic       exp_tick;
        logic       exp_wrap;
        logic       exp_pend;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   checks = 0;
    int   failures = 0;

    function automatic void add(input logic rst, input logic hb, input logic vb,
                                input logic wr, input logic [8:0] din, input logic en,
                                input logic dn, input logic [8:0] line, input logic tick,
                                input logic wrp, input logic pend);
        vec_t v;
        v.rst = rst; v.hb = hb; v.vb = vb; v.wr = wr; v.din = din; v.en = en; v.dn = dn;
        v.exp_line = line; v.exp_tick = tick; v.exp_wrap = wrp; v.exp_pend = pend;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int idx, input logic [8:0] act,
                         input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d actual=0x%0h required=0x%0h", name, idx, act, exp);
        end
    endtask

    initial begin
        logic [8:0] ln;
        vec_t e;

        // Reset state, and writes ignored under reset
        add(1, 0, 1, 0, 9'h000, 1, 0, 9'h000, 0, 0, 0);
        add(1, 0, 1, 1, 9'h055, 1, 0, 9'h000, 0, 0, 0);
        // Frame start: write in VBL (no pending), LOAD takes shadow
        add(0, 0, 1, 1, 9'h1F8, 1, 0, 9'h000, 0, 0, 0);
        add(0, 0, 0, 0, 9'h000, 1, 0, 9'h000, 0, 0, 0);
        add(0, 0, 0, 0, 9'h000, 1, 0, 9'h1F8, 0, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            ln = 9'(9'h1F8 + k);
            add(0, 1, 0, 0, 9'h000, 1, 0, ln, 1, (k == 8), 0);
            add(0, 0, 0, 0, 9'h000, 1, 0, ln, 0, 0, 0);
        end
        for (int k = 1; k <= 2; k++) begin
            ln = 9'(k);
            add(0, 1, 0, 0, 9'h000, 1, 0, ln, 1, 0, 0);
            add(0, 0, 0, 0, 9'h000, 1, 0, ln, 0, 0, 0);
        end
        // Down count through zero
        for (int k = 1; k <= 3; k++) begin
            ln = 9'(2 - k);
            add(0, 1, 0, 0, 9'h000, 1, 1, ln, 1, (k == 3), 0);
            add(0, 0, 0, 0, 9'h000, 1, 1, ln, 0, 0, 0);
        end
        // Mid-frame writes reload on next rise without wrap
        add(0, 0, 0, 1, 9'h040, 1, 0, 9'h1FF, 0, 0, 1);
        add(0, 1, 0, 0, 9'h000, 1, 0, 9'h040, 1, 0, 0);
        add(0, 0, 0, 0, 9'h000, 1, 0, 9'h040, 0, 0, 0);
        add(0, 0, 0, 1, 9'h100, 1, 0, 9'h040, 0, 0, 1);
        add(0, 1, 0, 0, 9'h000, 1, 0, 9'h100, 1, 0, 0);
        add(0, 0, 0, 0, 9'h000, 1, 0, 9'h100, 0, 0, 0);
        add(0, 1, 0, 0, 9'h000, 1, 0, 9'h101, 1, 0, 0);
        add(0, 0, 0, 0, 9'h000, 1, 0, 9'h101, 0, 0, 0);
        // Write colliding with hblank rise
        add(0, 0, 0, 1, 9'h010, 1, 0, 9'h101, 0, 0, 1);
        add(0, 1, 0, 0, 9'h000, 1, 0, 9'h010, 1, 0, 0);
        add(0, 0, 0, 0, 9'h000, 1, 0, 9'h010, 0, 0, 0);
        add(0, 1, 0, 1, 9'h080, 1, 0, 9'h011, 1, 0, 1);
        add(0, 0, 0, 0, 9'h000, 1, 0, 9'h011, 0, 0, 1);
        add(0, 1, 0, 0, 9'h000, 1, 0, 9'h080, 1, 0, 0);
        add(0, 0, 0, 0, 9'h000, 1, 0, 9'h080, 0, 0, 0);
        // Hold with count_en=0; pending reload still happens
        for (int k = 0; k < 4; k++) begin
            add(0, 1, 0, 0, 9'h000, 0, 0, 9'h080, 0, 0, 0);
            add(0, 0, 0, 0, 9'h000, 0, 0, 9'h080, 0, 0, 0);
        end
        add(0, 0, 0, 1, 9'h0F0, 0, 0, 9'h080, 0, 0, 1);
        add(0, 1, 0, 0, 9'h000, 0, 0, 9'h0F0, 1, 0, 0);
        add(0, 0, 0, 0, 9'h000, 0, 0, 9'h0F0, 0, 0, 0);
        // vblank beats a coincident rise; write bypass in LOAD cycle
        add(0, 1, 1, 0, 9'h000, 1, 0, 9'h0F0, 0, 0, 0);
        add(0, 0, 1, 0, 9'h000, 1, 0, 9'h0F0, 0, 0, 0);
        add(0, 0, 0, 0, 9'h000, 1, 0, 9'h0F0, 0, 0, 0);
        add(0, 0, 0, 1, 9'h0AA, 1, 0, 9'h0AA, 0, 0, 0);
        add(0, 1, 0, 0, 9'h000, 1, 0, 9'h0AB, 1, 0, 0);
        add(0, 0, 0, 0, 9'h000, 1, 0, 9'h0AB, 0, 0, 0);
        // Reset mid-frame discards pending reload
        add(0, 0, 0, 1, 9'h123, 1, 0, 9'h0AB, 0, 0, 1);
        add(1, 0, 0, 0, 9'h000, 1, 0, 9'h000, 0, 0, 0);
        add(0, 0, 0, 0, 9'h000, 1, 0, 9'h000, 0, 0, 0);
        add(0, 0, 0, 0, 9'h000, 1, 0, 9'h000, 0, 0, 0);
        add(0, 1, 0, 0, 9'h000, 1, 0, 9'h001, 1, 0, 0);
        add(0, 0, 0, 0, 9'h000, 1, 0, 9'h001, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset       = vecs[i].rst;
            hblank      = vecs[i].hb;
            vblank      = vecs[i].vb;
            vscroll_wr  = vecs[i].wr;
            vscroll_din = vecs[i].din;
            count_en    = vecs[i].en;
            dir         = vecs[i].dn;
            sb.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            $display("vec=%0d rst=%0b hb=%0b vb=%0b wr=%0b din=0x%0h pf_line=0x%0h tick=%0b wrap=%0b pend=%0b",
                     i, e.rst, e.hb, e.vb, e.wr, e.din, pf_line, line_tick, wrap, pending);
            check("pf_line",   i, pf_line,            e.exp_line);
            check("fine_y",    i, {6'd0, fine_y},     {6'd0, e.exp_line[2:0]});
            check("tile_row",  i, {3'd0, tile_row},   {3'd0, e.exp_line[8:3]});
            check("line_tick", i, {8'd0, line_tick},  {8'd0, e.exp_tick});
            check("wrap",      i, {8'd0, wrap},       {8'd0, e.exp_wrap});
            check("pending",   i, {8'd0, pending},    {8'd0, e.exp_pend});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pf_vscroll_ctrl.md
PF_VSCROLL_CTRL -- requirements
Module: pf_vscroll_ctrl

Interface
REQ-001 The block SHALL use one clock, clk, and a synchronous, active-high reset, reset.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 hblank  input  1  horizontal blank, active high, synchronous to clk.
REQ-005 vblank  input  1  vertical blank, active high, synchronous to clk.
REQ-006 vscroll_wr  input  1  one-cycle CPU write strobe for the vertical scroll register.
REQ-007 vscroll_din  input  9  scroll value written by the CPU.
REQ-008 count_en  input  1  1 = line counter advances on hblank rise; 0 = hold.
REQ-009 dir  input  1  0 = count up, 1 = count down.
REQ-010 pf_line  output  9  current playfield line (registered).
REQ-011 fine_y  output  3  pf_line[2:0], pixel row within a tile.
REQ-012 tile_row  output  6  pf_line[8:3], tile row index.
REQ-013 line_tick  output  1  one-cycle pulse when pf_line changes due to an hblank rise.
REQ-014 wrap  output  1  one-cycle pulse when the count wraps (511->0 up, 0->511 down).
REQ-015 pending  output  1  a mid-frame scroll write is waiting for the next hblank rise.

Function
REQ-016 The block SHALL hold a 9-bit shadow register that loads vscroll_din on every cycle in which vscroll_wr=1, in any state.
REQ-017 The block SHALL register hblank each cycle and define hb_rise = hblank & ~hblank_q.
REQ-018 The state machine SHALL have three states: VBL, LOAD and ACTIVE.
REQ-019 In VBL, the state SHALL go to LOAD in the first cycle with vblank=0; pf_line holds.
REQ-020 In LOAD (exactly one cycle), pf_line SHALL load vscroll_din if vscroll_wr=1 that cycle, otherwise shadow; pending clears; next state is ACTIVE.
REQ-021 In ACTIVE, vblank=1 SHALL send the state to VBL on the next edge, with no pf_line update that cycle, even if hb_rise=1.
REQ-022 In ACTIVE, hb_rise with pending=1 SHALL load pf_line from shadow and clear pending, regardless of count_en; no wrap pulse.
REQ-023 In ACTIVE, hb_rise with pending=0 and count_en=1 SHALL set pf_line to pf_line+1 (dir=0) or pf_line-1 (dir=1), modulo 512.
REQ-024 In ACTIVE, hb_rise with pending=0 and count_en=0 SHALL hold pf_line and produce no line_tick.
REQ-025 A vscroll_wr in ACTIVE SHALL set pending=1.
REQ-026 If vscroll_wr and hb_rise occur in the same ACTIVE cycle, that edge SHALL use the pre-write pending/counter path, and pending SHALL be 1 afterwards, so the reload occurs at the following hb_rise.
REQ-027 vscroll_wr in VBL SHALL update shadow only and SHALL NOT set pending.
REQ-028 line_tick SHALL be registered and asserted in the cycle after any REQ-022/023 update, coincident with the new pf_line.
REQ-029 wrap SHALL be asserted with line_tick only for a REQ-023 step from 511 to 0 (up) or from 0 to 511 (down).
REQ-030 fine_y and tile_row SHALL be combinational slices of registered pf_line (zero added latency).

Reset
REQ-031 While reset=1 the block SHALL set state=VBL, pf_line=0, shadow=0, hblank_q=1, pending=0, line_tick=0 and wrap=0; reset overrides all other inputs.
REQ-032 Reset asserted mid-frame SHALL discard any pending reload.
REQ-033 After reset deassertion with vblank=0, the block SHALL pass through LOAD and load pf_line=shadow (0).

Verification
REQ-034 Frame start: write 0x1F8 in VBL, drop vblank -> LOAD cycle sets pf_line=0x1F8; then 8 hblank rises (up, count_en=1) -> 0x1F9..0x1FF, then 0x000 with wrap=1 on the 8th tick only.
REQ-035 Down count: pf_line=0x002, dir=1 -> three hblank rises give 0x001, 0x000, 0x1FF; wrap pulses only with 0x1FF.
REQ-036 Mid-frame write: pf_line=0x040 in ACTIVE, write 0x100 -> pending=1; next hb_rise gives pf_line=0x100, line_tick=1, wrap=0, pending=0; next rise gives 0x101.
REQ-037 Collision: vscroll_wr(0x080) and hb_rise in same cycle at pf_line=0x010 -> pf_line=0x011, pending=1; following rise gives 0x080.
REQ-038 Hold and bypass: count_en=0 for 4 hblank rises -> pf_line unchanged, no line_tick; vscroll_wr(0x0AA) in the LOAD cycle -> pf_line=0x0AA.
REQ-039 Reset mid-frame with pending=1 -> pf_line=0, pending=0, state VBL; vblank=0 then gives LOAD with pf_line=0.
